// File: rtl/uart_pkg.sv
// Shared UART types and constants.
//   parity_e    : parity mode selector (none / odd / even)
//   tx_state_e  : transmitter frame states
//   IDLE_LEVEL  : line level while no frame is being sent
//   parity_bit  : turns the XOR of the data bits into the transmitted parity bit
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_ODD,
    PARITY_EVEN
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic IDLE_LEVEL = 1'b1;

  // ones_xor is the reduction XOR of the data word; odd parity inverts it so
  // that data plus parity always holds an odd number of ones.
  function automatic logic parity_bit(input parity_e mode, input logic ones_xor);
    return (mode == PARITY_ODD) ? ~ones_xor : ones_xor;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit clock divider for the UART.
// Counts 0..CLKS_PER_BIT-1 and pulses bit_done on the terminal count, then
// wraps to 0 so consecutive bits are back to back.
// Ports:
//   CLK      in  system clock
//   Reset    in  asynchronous active-high reset
//   clear    in  holds the count at 0 (line idle)
//   bit_done out one-cycle pulse on the last cycle of each bit period
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign bit_done = !clear && (count == TERMINAL);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clear || bit_done) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with valid/ready input handshake.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits; every bit is held for CLKS_PER_BIT clocks.
// Ports:
//   CLK     in  system clock
//   Reset   in  asynchronous active-high reset
//   EN      in  enable; gates acceptance of new words only
//   DataIN  in  word to send, captured on the accept edge
//   Valid   in  DataIN holds a word to send
//   Ready   out a word can be accepted this cycle
//   tx      out serial line, idle high
//   Busy    out frame in progress
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 EN,
  input  logic [DATA_BITS-1:0] DataIN,
  input  logic                 Valid,
  output logic                 Ready,
  output logic                 tx,
  output logic                 Busy
);

  import uart_pkg::*;

  // The PARITY parameter shadows the PARITY state name, so the state is
  // always referenced through the package.
  localparam parity_e PAR_MODE = parity_e'(PARITY);

  localparam int DCW = $clog2(DATA_BITS);
  localparam logic [DCW-1:0] LAST_DATA = DCW'(DATA_BITS - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e            state;
  tx_state_e            state_next;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DCW-1:0]       data_cnt;
  logic [DCW-1:0]       data_cnt_d;
  logic                 stop_cnt;
  logic                 stop_cnt_d;
  logic                 parity_q;
  logic                 parity_d;
  logic                 bit_done;
  logic                 timer_clear;
  logic                 last_stop;
  logic                 accept;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK     (CLK),
    .Reset   (Reset),
    .clear   (timer_clear),
    .bit_done(bit_done)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      shift_q  <= '0;
      data_cnt <= '0;
      stop_cnt <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      state    <= state_next;
      shift_q  <= shift_d;
      data_cnt <= data_cnt_d;
      stop_cnt <= stop_cnt_d;
      parity_q <= parity_d;
    end
  end

  always_comb begin
    state_next  = state;
    shift_d     = shift_q;
    data_cnt_d  = data_cnt;
    stop_cnt_d  = stop_cnt;
    parity_d    = parity_q;
    tx          = IDLE_LEVEL;
    Busy        = (state != IDLE);
    timer_clear = (state == IDLE);

    // Ready opens on the final cycle of the last stop bit as well as in IDLE,
    // so a waiting word starts its start bit with no idle gap.
    last_stop = (state == STOP) && bit_done && (stop_cnt == LAST_STOP);
    Ready     = !Reset && EN && ((state == IDLE) || last_stop);
    accept    = Valid && Ready;

    case (state)
      IDLE: begin
        tx = IDLE_LEVEL;
      end
      START: begin
        tx = 1'b0;
        if (bit_done) begin
          state_next = DATA;
        end
      end
      DATA: begin
        tx = shift_q[0];
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (data_cnt == LAST_DATA) begin
            data_cnt_d = '0;
            state_next = (PAR_MODE == PARITY_NONE) ? STOP : uart_pkg::PARITY;
          end else begin
            data_cnt_d = data_cnt + 1'b1;
          end
        end
      end
      uart_pkg::PARITY: begin
        tx = parity_q;
        if (bit_done) begin
          state_next = STOP;
        end
      end
      STOP: begin
        tx = 1'b1;
        if (bit_done) begin
          if (last_stop) begin
            stop_cnt_d = 1'b0;
            state_next = IDLE;
          end else begin
            stop_cnt_d = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Accept only happens in IDLE or on the last stop cycle, so it overrides
    // whatever the state case chose.
    if (accept) begin
      state_next = START;
      shift_d    = DataIN;
      parity_d   = parity_bit(PAR_MODE, ^DataIN);
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

  localparam int CPB = 4;

  typedef struct packed {
    logic tx;
    logic last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data_in = '0;
  logic [1:0] sel = 2'd0;
  logic [3:0] tx_v, busy_v, ready_v;
  logic       tx_m, busy_m, ready_m;

  int checks = 0;
  int passes = 0;
  exp_t exp_q[$];

  // sel: 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 5N2
  int dbits_of [4] = '{8, 8, 8, 5};
  int par_of   [4] = '{0, 2, 1, 0};
  int stop_of  [4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  assign tx_m    = tx_v[sel];
  assign busy_m  = busy_v[sel];
  assign ready_m = ready_v[sel];

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .CLK(clk), .Reset(rst), .EN(en), .DataIN(data_in), .Valid(valid),
    .Ready(ready_v[0]), .tx(tx_v[0]), .Busy(busy_v[0]));

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .CLK(clk), .Reset(rst), .EN(en), .DataIN(data_in), .Valid(valid),
    .Ready(ready_v[1]), .tx(tx_v[1]), .Busy(busy_v[1]));

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .CLK(clk), .Reset(rst), .EN(en), .DataIN(data_in), .Valid(valid),
    .Ready(ready_v[2]), .tx(tx_v[2]), .Busy(busy_v[2]));

  uart_tx_frame #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u_5n2 (
    .CLK(clk), .Reset(rst), .EN(en), .DataIN(data_in[4:0]), .Valid(valid),
    .Ready(ready_v[3]), .tx(tx_v[3]), .Busy(busy_v[3]));

  // Reference frame: expected tx level for every clock of the frame.
  task automatic push_frame(input logic [7:0] data, input int s);
    logic bits[$];
    logic x;
    exp_t e;
    x = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < dbits_of[s]; i++) begin
      bits.push_back(data[i]);
      x = x ^ data[i];
    end
    if (par_of[s] == 2) bits.push_back(x);
    else if (par_of[s] == 1) bits.push_back(~x);
    for (int i = 0; i < stop_of[s]; i++) bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int c = 0; c < CPB; c++) begin
        e.tx = bits[b];
        e.last = (b == bits.size() - 1) && (c == CPB - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one word, waits for the accept edge, then scrambles DataIN.
  task automatic send_word(input logic [7:0] data);
    step();
    valid = 1'b1;
    data_in = data;
    push_frame(data, int'(sel));
    step();
    valid = 1'b0;
    data_in = ~data;
  endtask

  task automatic test_reset();
    en = 1'b1;
    repeat (5) begin
      step();
      checks++; if (ready_m !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready_m); else passes++;
    end
    checks++; if (tx_m !== 1'b1) $display("FAIL reset_tx got=%b exp=1", tx_m); else passes++;
    checks++; if (busy_m !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_m); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (ready_m !== 1'b1) $display("FAIL release_ready got=%b exp=1", ready_m); else passes++;
  endtask

  task automatic test_8n1();
    exp_t e;
    sel = 2'd0;
    send_word(8'hF0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++; if (tx_m !== e.tx) $display("FAIL 8n1_tx idx=%0d got=%b exp=%b", i, tx_m, e.tx); else passes++;
      checks++; if (busy_m !== 1'b1) $display("FAIL 8n1_busy idx=%0d got=%b exp=1", i, busy_m); else passes++;
      checks++; if (ready_m !== (e.last & en)) $display("FAIL 8n1_ready idx=%0d got=%b exp=%b", i, ready_m, e.last & en); else passes++;
      step();
    end
    checks++; if (busy_m !== 1'b0) $display("FAIL 8n1_end_busy got=%b exp=0", busy_m); else passes++;
    checks++; if (tx_m !== 1'b1) $display("FAIL 8n1_end_tx got=%b exp=1", tx_m); else passes++;
  endtask

  task automatic test_parity();
    exp_t e;
    logic [1:0] sels [3] = '{2'd1, 2'd2, 2'd1};
    logic [7:0] words [3] = '{8'hF0, 8'hF0, 8'h07};
    for (int k = 0; k < 3; k++) begin
      repeat (48) step();
      sel = sels[k];
      send_word(words[k]);
      for (int i = 0; exp_q.size() > 0; i++) begin
        e = exp_q.pop_front();
        checks++; if (tx_m !== e.tx) $display("FAIL parity%0d_tx idx=%0d got=%b exp=%b", k, i, tx_m, e.tx); else passes++;
        checks++; if (busy_m !== 1'b1) $display("FAIL parity%0d_busy idx=%0d got=%b exp=1", k, i, busy_m); else passes++;
        checks++; if (ready_m !== (e.last & en)) $display("FAIL parity%0d_ready idx=%0d got=%b exp=%b", k, i, ready_m, e.last & en); else passes++;
        step();
      end
      checks++; if (busy_m !== 1'b0) $display("FAIL parity%0d_end_busy got=%b exp=0", k, busy_m); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    repeat (48) step();
    sel = 2'd0;
    step();
    valid = 1'b1;
    data_in = 8'hA5;
    push_frame(8'hA5, 0);
    step();
    data_in = 8'h3C;
    push_frame(8'h3C, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++; if (tx_m !== e.tx) $display("FAIL b2b_tx idx=%0d got=%b exp=%b", i, tx_m, e.tx); else passes++;
      checks++; if (busy_m !== 1'b1) $display("FAIL b2b_busy idx=%0d got=%b exp=1", i, busy_m); else passes++;
      checks++; if (ready_m !== (e.last & en)) $display("FAIL b2b_ready idx=%0d got=%b exp=%b", i, ready_m, e.last & en); else passes++;
      if (i == 40) begin
        valid = 1'b0;
        data_in = 8'h00;
      end
      step();
    end
    checks++; if (busy_m !== 1'b0) $display("FAIL b2b_end_busy got=%b exp=0", busy_m); else passes++;
  endtask

  task automatic test_two_stop();
    exp_t e;
    repeat (48) step();
    sel = 2'd3;
    send_word(8'h15);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++; if (tx_m !== e.tx) $display("FAIL 5n2_tx idx=%0d got=%b exp=%b", i, tx_m, e.tx); else passes++;
      checks++; if (busy_m !== 1'b1) $display("FAIL 5n2_busy idx=%0d got=%b exp=1", i, busy_m); else passes++;
      checks++; if (ready_m !== (e.last & en)) $display("FAIL 5n2_ready idx=%0d got=%b exp=%b", i, ready_m, e.last & en); else passes++;
      step();
    end
    checks++; if (busy_m !== 1'b0) $display("FAIL 5n2_end_busy got=%b exp=0", busy_m); else passes++;
  endtask

  task automatic test_enable();
    exp_t e;
    repeat (48) step();
    sel = 2'd0;
    en = 1'b0;
    valid = 1'b1;
    data_in = 8'h5A;
    repeat (20) begin
      step();
      checks++; if (ready_m !== 1'b0) $display("FAIL en_off_ready got=%b exp=0", ready_m); else passes++;
      checks++; if (tx_m !== 1'b1) $display("FAIL en_off_tx got=%b exp=1", tx_m); else passes++;
      checks++; if (busy_m !== 1'b0) $display("FAIL en_off_busy got=%b exp=0", busy_m); else passes++;
    end
    en = 1'b1;
    push_frame(8'h5A, 0);
    step();
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i == 4) en = 1'b0;
      if (i == 20) en = 1'b1;
      if (i == 30) en = 1'b0;
      #1;
      e = exp_q.pop_front();
      checks++; if (tx_m !== e.tx) $display("FAIL en_mid_tx idx=%0d got=%b exp=%b", i, tx_m, e.tx); else passes++;
      checks++; if (busy_m !== 1'b1) $display("FAIL en_mid_busy idx=%0d got=%b exp=1", i, busy_m); else passes++;
      checks++; if (ready_m !== (e.last & en)) $display("FAIL en_mid_ready idx=%0d got=%b exp=%b", i, ready_m, e.last & en); else passes++;
      step();
    end
    repeat (5) begin
      checks++; if (busy_m !== 1'b0) $display("FAIL en_after_busy got=%b exp=0", busy_m); else passes++;
      checks++; if (tx_m !== 1'b1) $display("FAIL en_after_tx got=%b exp=1", tx_m); else passes++;
      step();
    end
    valid = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    exp_t e;
    repeat (48) step();
    sel = 2'd0;
    send_word(8'hC3);
    for (int i = 0; i < 18; i++) begin
      e = exp_q.pop_front();
      checks++; if (tx_m !== e.tx) $display("FAIL rstmid_pre_tx idx=%0d got=%b exp=%b", i, tx_m, e.tx); else passes++;
      if (i < 17) step();
    end
    exp_q.delete();
    rst = 1'b1;
    #1;
    checks++; if (tx_m !== 1'b1) $display("FAIL rstmid_tx got=%b exp=1", tx_m); else passes++;
    checks++; if (busy_m !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy_m); else passes++;
    checks++; if (ready_m !== 1'b0) $display("FAIL rstmid_ready got=%b exp=0", ready_m); else passes++;
    repeat (2) step();
    rst = 1'b0;
    #1;
    checks++; if (ready_m !== 1'b1) $display("FAIL rstmid_release_ready got=%b exp=1", ready_m); else passes++;
    send_word(8'h96);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++; if (tx_m !== e.tx) $display("FAIL rstmid_post_tx idx=%0d got=%b exp=%b", i, tx_m, e.tx); else passes++;
      checks++; if (busy_m !== 1'b1) $display("FAIL rstmid_post_busy idx=%0d got=%b exp=1", i, busy_m); else passes++;
      step();
    end
    checks++; if (busy_m !== 1'b0) $display("FAIL rstmid_end_busy got=%b exp=0", busy_m); else passes++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d passes=%0d", checks, passes);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_two_stop();
    test_enable();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
